// File: rtl/cv_ctrl_scanner.sv
// rtl/cv_ctrl_scanner.sv - ColecoVision controller scanner with debounced joystick word
// Optional spinner quadrature decoder is built when CV_SCAN_SPINNER_EN is defined.
module cv_ctrl_scanner #(
    parameter int SETTLE   = 64,
    parameter int GAP      = 16,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    output logic        p5_n_o,
    output logic        p8_n_o,
    input  logic [3:0]  p_i,
    input  logic        p6_n_i,
    input  logic        p7_i,
    input  logic        p9_i,
    output logic [19:0] joy_o,
    output logic        frame_o,
    output logic [7:0]  spin_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_JOY    = 3'd1;
    localparam logic [2:0] S_GAP1   = 3'd2;
    localparam logic [2:0] S_KEY    = 3'd3;
    localparam logic [2:0] S_GAP2   = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    localparam int CW = 16;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP - 1);
    localparam logic [3:0]    DEB_TARGET  = 4'(DEBOUNCE);

    logic [2:0]    state, state_next;
    logic [CW-1:0] cnt;
    logic [3:0]    p_s1, p_s2;
    logic          p6_s1, p6_s2;
    logic [4:0]    dirs_q;
    logic [3:0]    code_q;
    logic          f2_q;
    logic [19:0]   prev_cand, cand;
    logic [3:0]    match, match_n;
    logic [13:0]   key;

    // key bits: [9:0] digits, [10] *, [11] #, [12] purple, [13] blue
    function automatic logic [13:0] key_decode(input logic [3:0] c);
        logic [13:0] k;
        k = '0;
        case (c)
            4'b0011: k[0]  = 1'b1;
            4'b1110: k[1]  = 1'b1;
            4'b1101: k[2]  = 1'b1;
            4'b0110: k[3]  = 1'b1;
            4'b0001: k[4]  = 1'b1;
            4'b1001: k[5]  = 1'b1;
            4'b0111: k[6]  = 1'b1;
            4'b1100: k[7]  = 1'b1;
            4'b1000: k[8]  = 1'b1;
            4'b1011: k[9]  = 1'b1;
            4'b1010: k[10] = 1'b1;
            4'b0101: k[11] = 1'b1;
            4'b0100: k[12] = 1'b1;
            4'b0010: k[13] = 1'b1;
            default: k = '0;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            p_s1  <= 4'hF;
            p_s2  <= 4'hF;
            p6_s1 <= 1'b1;
            p6_s2 <= 1'b1;
        end else begin
            p_s1  <= p_i;
            p_s2  <= p_s1;
            p6_s1 <= p6_n_i;
            p6_s2 <= p6_s1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (enable_i) state_next = S_JOY;
            S_JOY:    if (cnt == SETTLE_LAST) state_next = S_GAP1;
            S_GAP1:   if (cnt == GAP_LAST) state_next = S_KEY;
            S_KEY:    if (cnt == SETTLE_LAST) state_next = S_GAP2;
            S_GAP2:   if (cnt == GAP_LAST) state_next = S_COMMIT;
            S_COMMIT: state_next = S_JOY;
            default:  state_next = S_IDLE;
        endcase
        if (!enable_i) state_next = S_IDLE;
    end

    // Selects are registered from the next state so they change glitch-free with the FSM.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            p5_n_o  <= 1'b1;
            p8_n_o  <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= (state_next != state || state_next == S_IDLE) ? '0 : cnt + CW'(1);
            p5_n_o  <= (state_next != S_KEY);
            p8_n_o  <= (state_next != S_JOY);
            frame_o <= (state_next == S_COMMIT);
        end
    end

    assign key     = key_decode(code_q);
    assign cand    = {key[13], key[12], key[9:0], key[11], key[10], f2_q, dirs_q};
    assign match_n = (match != 4'd0 && cand == prev_cand) ?
                     ((match == 4'hF) ? 4'hF : match + 4'd1) : 4'd1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dirs_q    <= '0;
            code_q    <= 4'hF;
            f2_q      <= 1'b0;
            prev_cand <= '0;
            match     <= '0;
            joy_o     <= '0;
        end else begin
            if (state == S_JOY && state_next == S_GAP1)
                dirs_q <= ~{p6_s2, p_s2};
            if (state == S_KEY && state_next == S_GAP2) begin
                code_q <= p_s2;
                f2_q   <= ~p6_s2;
            end
            if (state == S_IDLE) begin
                match <= '0;
            end else if (state == S_COMMIT && state_next == S_JOY) begin
                match     <= match_n;
                prev_cand <= cand;
                if (match_n >= DEB_TARGET)
                    joy_o <= cand;
            end
        end
    end

`ifdef CV_SCAN_SPINNER_EN
    logic [1:0] q_s1, q_s2, q_prev, step;

    // Gray to binary position; a forward step is a position delta of +1 modulo 4.
    assign step = {q_s2[1], ^q_s2} - {q_prev[1], ^q_prev};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            q_s1   <= '0;
            q_s2   <= '0;
            q_prev <= '0;
            spin_o <= '0;
        end else begin
            q_s1   <= {p7_i, p9_i};
            q_s2   <= q_s1;
            q_prev <= q_s2;
            if (step == 2'd1)
                spin_o <= spin_o + 8'd1;
            else if (step == 2'd3)
                spin_o <= spin_o - 8'd1;
        end
    end
`else
    logic unused_spin;
    assign unused_spin = p7_i ^ p9_i;
    assign spin_o      = '0;
`endif

endmodule

// File: tb/tb_cv_ctrl_scanner.sv
// tb/tb_cv_ctrl_scanner.sv - self-checking bench for cv_ctrl_scanner
module tb_cv_ctrl_scanner;
    localparam int SETTLE = 8;
    localparam int GAP    = 4;

    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic [3:0]  p;
    logic        p6, p7, p9;
    logic        p5a, p8a, p5b, p8b, frame_a, frame_b;
    logic [19:0] joy_a, joy_b;
    logic [7:0]  spin_a, spin_b;

    logic [4:0]  c_dirs;
    logic [3:0]  c_code;
    logic        c_f2;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;

    always #5 clk = ~clk;

    cv_ctrl_scanner #(.SETTLE(SETTLE), .GAP(GAP), .DEBOUNCE(2)) u_dut_d2 (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .p5_n_o(p5a), .p8_n_o(p8a),
        .p_i(p), .p6_n_i(p6), .p7_i(p7), .p9_i(p9), .joy_o(joy_a), .frame_o(frame_a),
        .spin_o(spin_a));

    cv_ctrl_scanner #(.SETTLE(SETTLE), .GAP(GAP), .DEBOUNCE(1)) u_dut_d1 (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(enable), .p5_n_o(p5b), .p8_n_o(p8b),
        .p_i(p), .p6_n_i(p6), .p7_i(p7), .p9_i(p9), .joy_o(joy_b), .frame_o(frame_b),
        .spin_o(spin_b));

    // Physical controller: {P1..P4} = ~{U,D,L,R} under P8, keypad code under P5.
    always_comb begin
        p  = 4'hF;
        p6 = 1'b1;
        if (!p8a) begin
            p  = ~c_dirs[3:0];
            p6 = ~c_dirs[4];
        end else if (!p5a) begin
            p  = c_code;
            p6 = ~c_f2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!(p5a | p8a)) begin
                errors++;
                $display("FAIL select_overlap actual p5=%b p8=%b expected one high", p5a, p8a);
            end
        end
        if (frame_a) frame_cnt++;
    end

    // Reference model: joy word is the newest candidate once the last D candidates agree.
    int          key_pos [16];
    logic [19:0] hist[$];
    logic [19:0] exp_a, exp_b;

    function automatic logic [19:0] cand_of(input logic [4:0] d, input logic [3:0] c, input logic f2);
        logic [19:0] r;
        r = {14'b0, f2, d};
        if (key_pos[c] >= 0) r[key_pos[c]] = 1'b1;
        return r;
    endfunction

    function automatic bit stable(input int d);
        if (hist.size() < d) return 1'b0;
        for (int i = 1; i < d; i++)
            if (hist[hist.size()-1-i] != hist[hist.size()-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_frame(input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_a) begin got = 1'b1; break; end
        end
        check({name, "_frame_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({name, "_frame_b"}, 32'(frame_b), 32'd1);
            hist.push_back(cand_of(c_dirs, c_code, c_f2));
            if (hist.size() > 15) void'(hist.pop_front());
            if (stable(2)) exp_a = hist[hist.size()-1];
            if (stable(1)) exp_b = hist[hist.size()-1];
            @(negedge clk);
            check({name, "_joy_d2"}, 32'(joy_a), 32'(exp_a));
            check({name, "_joy_d1"}, 32'(joy_b), 32'(exp_b));
        end
    endtask

    typedef struct {
        logic [4:0]  dirs;
        logic [3:0]  code;
        logic        f2;
        logic [19:0] exp;
    } vec_t;
    vec_t vecs[12];

    logic [1:0]  gseq [4];
    int          spin_model;
    logic [19:0] held;
    bit          got;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        key_pos = '{-1, 12, 19, 8, 18, 7, 11, 14, 16, 13, 6, 17, 15, 10, 9, -1};
        gseq    = '{2'b00, 2'b01, 2'b11, 2'b10};
        vecs[0]  = '{5'b11000, 4'b1111, 1'b0, 20'h00018};
        vecs[1]  = '{5'b00000, 4'b1001, 1'b1, 20'h02020};
        vecs[2]  = '{5'b00000, 4'b1111, 1'b0, 20'h00000};
        vecs[3]  = '{5'b00101, 4'b1010, 1'b0, 20'h00045};
        vecs[4]  = '{5'b00010, 4'b0101, 1'b0, 20'h00082};
        vecs[5]  = '{5'b00000, 4'b0100, 1'b0, 20'h40000};
        vecs[6]  = '{5'b00000, 4'b0010, 1'b0, 20'h80000};
        vecs[7]  = '{5'b00000, 4'b0011, 1'b0, 20'h00100};
        vecs[8]  = '{5'b01111, 4'b0000, 1'b0, 20'h0000F};
        vecs[9]  = '{5'b00000, 4'b0111, 1'b0, 20'h04000};
        vecs[10] = '{5'b00000, 4'b1000, 1'b0, 20'h10000};
        vecs[11] = '{5'b00000, 4'b1011, 1'b0, 20'h20000};
        exp_a = '0; exp_b = '0; spin_model = 0;

        rst_n = 1'b0; enable = 1'b0; p7 = 1'b0; p9 = 1'b0;
        c_dirs = '0; c_code = 4'hF; c_f2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p5", 32'(p5a), 32'd1);
        check("rst_p8", 32'(p8a), 32'd1);
        check("rst_joy", 32'(joy_a), 32'd0);
        check("rst_frame", 32'(frame_a), 32'd0);
        check("rst_spin", 32'(spin_a), 32'd0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_frames", 32'(frame_cnt), 32'd0);
        check("idle_p5", 32'(p5a), 32'd1);
        check("idle_p8", 32'(p8a), 32'd1);
        check("idle_joy", 32'(joy_a), 32'd0);

        c_dirs = 5'b11000;
        enable = 1'b1;
        do_frame("t2_f1");
        check("t2_not_before", 32'(joy_a), 32'h0);
        do_frame("t2_f2");
        check("t2_after_two", 32'(joy_a), 32'h00018);

        for (int v = 0; v < 12; v++) begin
            c_dirs = vecs[v].dirs; c_code = vecs[v].code; c_f2 = vecs[v].f2;
            repeat (3) do_frame($sformatf("vec%0d", v));
            check($sformatf("vec%0d_d2_const", v), 32'(joy_a), 32'(vecs[v].exp));
            check($sformatf("vec%0d_d1_const", v), 32'(joy_b), 32'(vecs[v].exp));
        end

        c_dirs = '0; c_f2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            c_code = (i % 2 == 0) ? 4'b1110 : 4'b1101;
            do_frame($sformatf("toggle%0d", i));
            check($sformatf("toggle%0d_hold", i), 32'(joy_a), 32'h20000);
            check($sformatf("toggle%0d_follow", i), 32'(joy_b), (i % 2 == 0) ? 32'h200 : 32'h400);
        end

        c_dirs = 5'b10001; c_code = 4'b0110; c_f2 = 1'b1;
        repeat (3) do_frame("pre_drop");
        held = joy_a;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!p5a) begin got = 1'b1; break; end
        end
        check("t5_key_seen", 32'(got), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t5_p5_release", 32'(p5a), 32'd1);
        check("t5_p8_release", 32'(p8a), 32'd1);
        repeat (40) @(negedge clk);
        check("t5_joy_hold", 32'(joy_a), 32'(held));
        check("t5_joy_hold_const", 32'(joy_a), 32'h00831);
        c_dirs = 5'b00100; c_code = 4'b1100; c_f2 = 1'b0;
        enable = 1'b1;
        hist.delete();
        @(negedge clk);
        check("t5_restart_joy", 32'(p8a), 32'd0);
        repeat (3) do_frame("t5_reenable");

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                c_dirs = 5'($urandom);
                c_code = 4'($urandom);
                c_f2   = 1'($urandom);
            end
            do_frame($sformatf("rand%0d", i));
        end

        enable = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 130; i++) begin
            {p7, p9} = gseq[i % 4];
            spin_model++;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
`ifdef CV_SCAN_SPINNER_EN
        check("spin_fwd", 32'(spin_a), 32'(8'(spin_model)));
        check("spin_fwd_const", 32'(spin_b), 32'h82);
`else
        check("spin_off_fwd", 32'(spin_a), 32'h0);
`endif
        for (int i = 1; i >= 0; i--) begin
            {p7, p9} = gseq[i];
            spin_model--;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
`ifdef CV_SCAN_SPINNER_EN
        check("spin_rev", 32'(spin_a), 32'(8'(spin_model)));
        check("spin_rev_const", 32'(spin_b), 32'h80);
`else
        check("spin_off_rev", 32'(spin_a), 32'h0);
`endif
        {p7, p9} = 2'b11;
        repeat (6) @(negedge clk);
`ifdef CV_SCAN_SPINNER_EN
        check("spin_illegal", 32'(spin_a), 32'h80);
`else
        check("spin_off_illegal", 32'(spin_b), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
